// File: rtl/int_sequencer.sv
// int_sequencer
// Hardware interrupt entry / return-from-interrupt sequencer for a simple
// pipelined CPU. On an interrupt it drains the pipeline, pushes the return
// PC (high half, low half) and the flags onto a downward-growing stack, then
// loads the vector address. On RTI it drains, pops the three words back in
// reverse order and restores PC and flags.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   int_in, rti_in    interrupt request / RTI decoded this cycle
//   pc_in, ccr_in     return address and current flags from the core
//   pop_data          data-memory read data, valid one cycle after pop
//   stall_fetch       hold PC and fetch/decode register
//   flush_fd          bubble into fetch/decode register
//   push, pop         data-memory write / read strobes
//   mem_addr          stack address of the current transfer
//   push_data         word written on push
//   counter           stack word index of the current transfer
//   sp                current stack pointer
//   pc_load(_addr)    one-cycle PC load strobe and target
//   ccr_restore/out   one-cycle flag restore strobe and value
//   int_ack           one-cycle acknowledge on handler entry
module int_sequencer #(
    parameter logic [31:0] SP_INIT      = 32'h0000_0FFF,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0002,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_in,
    input  logic        rti_in,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    input  logic [15:0] pop_data,
    output logic        stall_fetch,
    output logic        flush_fd,
    output logic        push,
    output logic        pop,
    output logic [31:0] mem_addr,
    output logic [15:0] push_data,
    output logic [1:0]  counter,
    output logic [31:0] sp,
    output logic        pc_load,
    output logic [31:0] pc_load_addr,
    output logic        ccr_restore,
    output logic [2:0]  ccr_out,
    output logic        int_ack
);

    typedef enum logic [3:0] {
        S_IDLE, S_DRAIN, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_CCR, S_JUMP,
        S_POP_CCR, S_POP_PCL, S_POP_PCH, S_RESTORE
    } state_t;

    localparam logic [2:0] LAST_DRAIN = 3'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic        r_is_rti;
    logic        r_pending;
    logic [2:0]  r_drain_cnt;
    logic [31:0] r_pc_saved;
    logic [2:0]  r_ccr;
    logic [2:0]  r_pop_ccr;
    logic [15:0] r_pop_pcl;
    logic [31:0] r_sp;

    logic        r_stall, r_flush, r_push, r_pop;
    logic [31:0] r_mem_addr;
    logic [15:0] r_push_data;
    logic [1:0]  r_counter;
    logic        r_pc_load, r_ccr_restore, r_int_ack;
    logic [31:0] r_pc_load_addr;
    logic [2:0]  r_ccr_out;

    state_t      w_nxt;
    logic        w_pend_nxt;
    logic [31:0] w_sp_nxt;
    logic        w_nxt_push, w_nxt_pop;
    logic [15:0] w_push_data;
    logic [1:0]  w_counter;

    // Next state and next pending flag.
    always_comb begin
        w_nxt      = r_state;
        w_pend_nxt = r_pending | int_in;
        case (r_state)
            S_IDLE: begin
                if (rti_in) begin
                    // RTI wins; a simultaneous int_in stays pending.
                    w_nxt = S_DRAIN;
                end else if (int_in || r_pending) begin
                    w_nxt      = S_DRAIN;
                    w_pend_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == LAST_DRAIN)
                    w_nxt = r_is_rti ? S_POP_CCR : S_PUSH_PCH;
            end
            S_PUSH_PCH: w_nxt = S_PUSH_PCL;
            S_PUSH_PCL: w_nxt = S_PUSH_CCR;
            S_PUSH_CCR: w_nxt = S_JUMP;
            S_POP_CCR:  w_nxt = S_POP_PCL;
            S_POP_PCL:  w_nxt = S_POP_PCH;
            S_POP_PCH:  w_nxt = S_RESTORE;
            default:    w_nxt = S_IDLE;   // JUMP, RESTORE
        endcase
    end

    // Stack pointer moves as each transfer state completes.
    always_comb begin
        case (r_state)
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_CCR: w_sp_nxt = r_sp - 32'd1;
            S_POP_CCR, S_POP_PCL, S_POP_PCH:    w_sp_nxt = r_sp + 32'd1;
            default:                            w_sp_nxt = r_sp;
        endcase
    end

    always_comb begin
        w_nxt_push  = 1'b0;
        w_nxt_pop   = 1'b0;
        w_push_data = 16'h0000;
        w_counter   = 2'd0;
        case (w_nxt)
            S_PUSH_PCH: begin w_nxt_push = 1'b1; w_push_data = r_pc_saved[31:16]; w_counter = 2'd0; end
            S_PUSH_PCL: begin w_nxt_push = 1'b1; w_push_data = r_pc_saved[15:0];  w_counter = 2'd1; end
            S_PUSH_CCR: begin w_nxt_push = 1'b1; w_push_data = {13'b0, r_ccr};    w_counter = 2'd2; end
            S_POP_CCR:  begin w_nxt_pop  = 1'b1; w_counter = 2'd2; end
            S_POP_PCL:  begin w_nxt_pop  = 1'b1; w_counter = 2'd1; end
            S_POP_PCH:  begin w_nxt_pop  = 1'b1; w_counter = 2'd0; end
            default: ;
        endcase
    end

    // Strobes that must line up with the transfer states (stall, flush,
    // push/pop, address, data) are registered from the next state. The
    // completion pulses are registered from the current state so RESTORE can
    // fold in the PC high word that arrives during RESTORE itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_is_rti       <= 1'b0;
            r_pending      <= 1'b0;
            r_drain_cnt    <= 3'd0;
            r_pc_saved     <= 32'h0;
            r_ccr          <= 3'd0;
            r_pop_ccr      <= 3'd0;
            r_pop_pcl      <= 16'h0;
            r_sp           <= SP_INIT;
            r_stall        <= 1'b0;
            r_flush        <= 1'b0;
            r_push         <= 1'b0;
            r_pop          <= 1'b0;
            r_mem_addr     <= 32'h0;
            r_push_data    <= 16'h0;
            r_counter      <= 2'd0;
            r_pc_load      <= 1'b0;
            r_pc_load_addr <= 32'h0;
            r_ccr_restore  <= 1'b0;
            r_ccr_out      <= 3'd0;
            r_int_ack      <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_pending <= w_pend_nxt;
            r_sp      <= w_sp_nxt;

            if (r_state == S_IDLE && w_nxt == S_DRAIN) begin
                r_is_rti <= rti_in;
                if (!rti_in)
                    r_pc_saved <= pc_in;
            end

            if (r_state == S_DRAIN && w_nxt == S_DRAIN)
                r_drain_cnt <= r_drain_cnt + 3'd1;
            else
                r_drain_cnt <= 3'd0;

            // Flags are taken once the pipeline has fully drained.
            if (r_state == S_DRAIN && r_drain_cnt == LAST_DRAIN)
                r_ccr <= ccr_in;

            // Read data trails each pop by one cycle.
            if (r_state == S_POP_PCL)
                r_pop_ccr <= pop_data[2:0];
            if (r_state == S_POP_PCH)
                r_pop_pcl <= pop_data;

            // Hold fetch when going busy or when a queued interrupt will
            // start on the very next cycle.
            r_stall     <= (w_nxt != S_IDLE) || w_pend_nxt;
            r_flush     <= (w_nxt == S_DRAIN) || (w_nxt == S_JUMP) || (w_nxt == S_RESTORE);
            r_push      <= w_nxt_push;
            r_pop       <= w_nxt_pop;
            r_push_data <= w_push_data;
            r_counter   <= w_counter;
            // Pushes write at sp, pops read from sp+1.
            r_mem_addr  <= w_nxt_push ? w_sp_nxt :
                           w_nxt_pop  ? w_sp_nxt + 32'd1 : 32'h0;

            r_pc_load     <= (r_state == S_JUMP) || (r_state == S_RESTORE);
            r_int_ack     <= (r_state == S_JUMP);
            r_ccr_restore <= (r_state == S_RESTORE);
            r_ccr_out     <= (r_state == S_RESTORE) ? r_pop_ccr : 3'd0;
            r_pc_load_addr <= (r_state == S_JUMP)    ? VECTOR_ADDR :
                              (r_state == S_RESTORE) ? {pop_data, r_pop_pcl} : 32'h0;
        end
    end

    assign stall_fetch  = r_stall;
    assign flush_fd     = r_flush;
    assign push         = r_push;
    assign pop          = r_pop;
    assign mem_addr     = r_mem_addr;
    assign push_data    = r_push_data;
    assign counter      = r_counter;
    assign sp           = r_sp;
    assign pc_load      = r_pc_load;
    assign pc_load_addr = r_pc_load_addr;
    assign ccr_restore  = r_ccr_restore;
    assign ccr_out      = r_ccr_out;
    assign int_ack      = r_int_ack;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a small stack memory model.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst, int_in, rti_in;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic [15:0] pop_data;
    logic        stall_fetch, flush_fd, push, pop;
    logic [31:0] mem_addr, sp, pc_load_addr;
    logic [15:0] push_data;
    logic [1:0]  counter;
    logic        pc_load, ccr_restore, int_ack;
    logic [2:0]  ccr_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Stack memory: synchronous write on push, read data one cycle after pop.
    logic [15:0] mem [0:8191];
    logic        tb_we = 1'b0;
    logic [12:0] tb_wa = 13'h0;
    logic [15:0] tb_wd = 16'h0;

    always @(posedge clk) begin
        if (push)       mem[mem_addr[12:0]] <= push_data;
        else if (tb_we) mem[tb_wa] <= tb_wd;
        pop_data <= pop ? mem[mem_addr[12:0]] : 16'h0;
    end

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk(clk), .rst(rst), .int_in(int_in), .rti_in(rti_in),
        .pc_in(pc_in), .ccr_in(ccr_in), .pop_data(pop_data),
        .stall_fetch(stall_fetch), .flush_fd(flush_fd), .push(push), .pop(pop),
        .mem_addr(mem_addr), .push_data(push_data), .counter(counter), .sp(sp),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .ccr_restore(ccr_restore),
        .ccr_out(ccr_out), .int_ack(int_ack)
    );

    // Expected output fields: ctl = {stall,flush,push,pop,counter},
    // pls = {pc_load,int_ack,ccr_restore}.
    logic [5:0]  e_ctl;
    logic [31:0] e_addr, e_la, e_sp;
    logic [15:0] e_dat;
    logic [2:0]  e_pls, e_co;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst = 1'b1; int_in = 1'b0; rti_in = 1'b0; pc_in = 32'h0; ccr_in = 3'd0;
        tick; tick;
        n_checks++;
        if ({stall_fetch, flush_fd, push, pop, counter, mem_addr, push_data,
             pc_load, int_ack, ccr_restore, pc_load_addr, ccr_out, sp} !==
            {6'b0, 32'h0, 16'h0, 3'b0, 32'h0, 3'b0, 32'h0000_0FFF}) begin
            n_fail++;
            $display("FAIL reset: got ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h, want all zero with sp=00000fff",
                     {stall_fetch, flush_fd, push, pop, counter}, mem_addr, push_data,
                     {pc_load, int_ack, ccr_restore}, pc_load_addr, ccr_out, sp);
        end
        rst = 1'b0;
    endtask

    // Interrupt entry from sp=0x0FFF; int_ack expected 8 cycles after int_in.
    task test_int_entry;
        pc_in = 32'h0001_2345; ccr_in = 3'b101; int_in = 1'b1;
        tick;
        int_in = 1'b0; pc_in = 32'hDEAD_BEEF;     // must already be latched
        for (int c = 1; c <= 9; c++) begin
            if (c == 4) ccr_in = 3'b010;          // flags latched at end of cycle 3
            e_ctl = 6'b0; e_addr = 32'h0; e_dat = 16'h0; e_pls = 3'b0; e_la = 32'h0; e_co = 3'b0;
            e_sp = 32'h0000_0FFC;
            case (c)
                1, 2, 3: begin e_ctl = 6'b110000; e_sp = 32'h0FFF; end
                4: begin e_ctl = 6'b101000; e_addr = 32'h0FFF; e_dat = 16'h0001; e_sp = 32'h0FFF; end
                5: begin e_ctl = 6'b101001; e_addr = 32'h0FFE; e_dat = 16'h2345; e_sp = 32'h0FFE; end
                6: begin e_ctl = 6'b101010; e_addr = 32'h0FFD; e_dat = 16'h0005; e_sp = 32'h0FFD; end
                7: e_ctl = 6'b110000;
                8: begin e_pls = 3'b110; e_la = 32'h0000_0002; end
                default: ;
            endcase
            n_checks++;
            if ({stall_fetch, flush_fd, push, pop, counter, mem_addr, push_data,
                 pc_load, int_ack, ccr_restore, pc_load_addr, ccr_out, sp} !==
                {e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp}) begin
                n_fail++;
                $display("FAIL int_entry cyc%0d: got ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h, want ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h",
                         c, {stall_fetch, flush_fd, push, pop, counter}, mem_addr, push_data,
                         {pc_load, int_ack, ccr_restore}, pc_load_addr, ccr_out, sp,
                         e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp);
            end
            tick;
        end
    endtask

    // Return from the frame pushed by test_int_entry.
    task test_rti;
        rti_in = 1'b1;
        tick;
        rti_in = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            e_ctl = 6'b0; e_addr = 32'h0; e_dat = 16'h0; e_pls = 3'b0; e_la = 32'h0; e_co = 3'b0;
            e_sp = 32'h0000_0FFF;
            case (c)
                1, 2, 3: begin e_ctl = 6'b110000; e_sp = 32'h0FFC; end
                4: begin e_ctl = 6'b100110; e_addr = 32'h0FFD; e_sp = 32'h0FFC; end
                5: begin e_ctl = 6'b100101; e_addr = 32'h0FFE; e_sp = 32'h0FFD; end
                6: begin e_ctl = 6'b100100; e_addr = 32'h0FFF; e_sp = 32'h0FFE; end
                7: e_ctl = 6'b110000;
                8: begin e_pls = 3'b101; e_la = 32'h0001_2345; e_co = 3'b101; end
                default: ;
            endcase
            n_checks++;
            if ({stall_fetch, flush_fd, push, pop, counter, mem_addr, push_data,
                 pc_load, int_ack, ccr_restore, pc_load_addr, ccr_out, sp} !==
                {e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp}) begin
                n_fail++;
                $display("FAIL rti cyc%0d: got ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h, want ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h",
                         c, {stall_fetch, flush_fd, push, pop, counter}, mem_addr, push_data,
                         {pc_load, int_ack, ccr_restore}, pc_load_addr, ccr_out, sp,
                         e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp);
            end
            tick;
        end
    endtask

    // int_in and rti_in together: RTI first, then the interrupt immediately.
    task test_both;
        tb_we = 1'b1;
        tb_wa = 13'h1000; tb_wd = 16'h0003; tick;
        tb_wa = 13'h1001; tb_wd = 16'h5678; tick;
        tb_wa = 13'h1002; tb_wd = 16'h0009; tick;
        tb_we = 1'b0;
        pc_in = 32'h00AB_CDEF; ccr_in = 3'b110; int_in = 1'b1; rti_in = 1'b1;
        tick;
        int_in = 1'b0; rti_in = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            e_ctl = 6'b0; e_addr = 32'h0; e_dat = 16'h0; e_pls = 3'b0; e_la = 32'h0; e_co = 3'b0;
            e_sp = 32'h0000_1002;
            case (c)
                1, 2, 3: begin e_ctl = 6'b110000; e_sp = 32'h0FFF; end
                4: begin e_ctl = 6'b100110; e_addr = 32'h1000; e_sp = 32'h0FFF; end
                5: begin e_ctl = 6'b100101; e_addr = 32'h1001; e_sp = 32'h1000; end
                6: begin e_ctl = 6'b100100; e_addr = 32'h1002; e_sp = 32'h1001; end
                7: e_ctl = 6'b110000;
                8: begin e_ctl = 6'b100000; e_pls = 3'b101; e_la = 32'h0009_5678; e_co = 3'b011; end
                9, 10, 11: e_ctl = 6'b110000;
                12: begin e_ctl = 6'b101000; e_addr = 32'h1002; e_dat = 16'h00AB; end
                13: begin e_ctl = 6'b101001; e_addr = 32'h1001; e_dat = 16'hCDEF; e_sp = 32'h1001; end
                14: begin e_ctl = 6'b101010; e_addr = 32'h1000; e_dat = 16'h0006; e_sp = 32'h1000; end
                15: begin e_ctl = 6'b110000; e_sp = 32'h0FFF; end
                16: begin e_pls = 3'b110; e_la = 32'h0000_0002; e_sp = 32'h0FFF; end
                default: e_sp = 32'h0FFF;
            endcase
            n_checks++;
            if ({stall_fetch, flush_fd, push, pop, counter, mem_addr, push_data,
                 pc_load, int_ack, ccr_restore, pc_load_addr, ccr_out, sp} !==
                {e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp}) begin
                n_fail++;
                $display("FAIL both cyc%0d: got ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h, want ctl=%b addr=%h dat=%h pls=%b la=%h co=%b sp=%h",
                         c, {stall_fetch, flush_fd, push, pop, counter}, mem_addr, push_data,
                         {pc_load, int_ack, ccr_restore}, pc_load_addr, ccr_out, sp,
                         e_ctl, e_addr, e_dat, e_pls, e_la, e_co, e_sp);
            end
            tick;
        end
    endtask

    // Two extra int_in pulses during a sequence yield exactly one more entry.
    task test_double_int;
        int acks;
        acks = 0;
        pc_in = 32'h0000_1111; ccr_in = 3'b001; int_in = 1'b1;
        tick;
        for (int c = 1; c <= 30; c++) begin
            int_in = (c == 2 || c == 5);
            if (int_ack) acks++;
            if (c == 8) begin
                n_checks++;
                if (int_ack !== 1'b1 || stall_fetch !== 1'b1) begin
                    n_fail++;
                    $display("FAIL double_first_ack: got ack=%b stall=%b, want ack=1 stall=1", int_ack, stall_fetch);
                end
            end
            if (c == 12) begin
                n_checks++;
                if (push !== 1'b1 || mem_addr !== 32'h0FFC || push_data !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL double_second_push: got push=%b addr=%h dat=%h, want push=1 addr=00000ffc dat=0000", push, mem_addr, push_data);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (int_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL double_second_ack: got ack=%b, want 1", int_ack);
                end
            end
            if (c == 17) begin
                n_checks++;
                if (stall_fetch !== 1'b0) begin
                    n_fail++;
                    $display("FAIL double_stall_release: got stall=%b, want 0", stall_fetch);
                end
            end
            tick;
        end
        int_in = 1'b0;
        n_checks++;
        if (acks != 2 || sp !== 32'h0000_0FF9) begin
            n_fail++;
            $display("FAIL double_count: got acks=%0d sp=%h, want acks=2 sp=00000ff9", acks, sp);
        end
    endtask

    // Reset in PUSH_PCL with an interrupt pending.
    task test_reset_mid;
        int bad;
        bad = 0;
        pc_in = 32'h0000_2222; int_in = 1'b1;
        tick;
        for (int c = 1; c <= 5; c++) begin
            int_in = (c == 2);
            if (c == 5) begin
                n_checks++;
                if (push !== 1'b1 || mem_addr !== 32'h0FF8 || counter !== 2'd1) begin
                    n_fail++;
                    $display("FAIL rstmid_pcl: got push=%b addr=%h cnt=%0d, want push=1 addr=00000ff8 cnt=1", push, mem_addr, counter);
                end
                rst = 1'b1;
            end
            tick;
        end
        rst = 1'b0;
        n_checks++;
        if ({stall_fetch, flush_fd, push, pop, counter, mem_addr, push_data,
             pc_load, int_ack, ccr_restore, sp} !==
            {6'b0, 32'h0, 16'h0, 3'b0, 32'h0000_0FFF}) begin
            n_fail++;
            $display("FAIL rstmid_state: got ctl=%b addr=%h dat=%h pls=%b sp=%h, want zeros with sp=00000fff",
                     {stall_fetch, flush_fd, push, pop, counter}, mem_addr, push_data,
                     {pc_load, int_ack, ccr_restore}, sp);
        end
        for (int c = 0; c < 15; c++) begin
            if (int_ack || stall_fetch || pc_load || push) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_pending: got %0d busy cycles after reset, want 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_int_entry;
        test_rti;
        test_both;
        test_double_int;
        test_reset_mid;
        test_int_entry;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
